// File: rtl/guess_uart_tx.sv
// guess_uart_tx: player-side UART transmitter for wireless hangman.
// Validates guessed letters as uppercase ASCII (A-Z), queues them in a small
// circular FIFO and sends each one as an 8N1 frame, LSB first.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   letter[7:0]      ASCII guess, sampled on the rising edge of send
//   send             level request, edge-detected internally
//   tx               serial line, idle high
//   busy             frame in flight or FIFO non-empty
//   tx_done          one-cycle pulse when a stop bit completes
//   overflow         one-cycle pulse when a valid guess is dropped (FIFO full)
//   bad_char         one-cycle pulse when the letter is not A-Z
//   count            FIFO occupancy
module guess_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 1042,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               letter,
  input  logic                     send,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done,
  output logic                     overflow,
  output logic                     bad_char,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            send_prev_q;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            tx_done_q, tx_done_d;
  logic            overflow_q, overflow_d;
  logic            bad_char_q, bad_char_d;

  logic            pop;
  logic            we;
  logic            push_req;
  logic            valid;
  logic            baud_end;
  logic [7:0]      head;

  // Frame sequencer: pops the FIFO head in IDLE or straight out of STOP.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_done_d = 1'b0;
    tx_d      = 1'b1;
    head      = mem_q[rd_ptr_q];
    baud_end  = (baud_q == BW'(CLKS_PER_BIT - 1));

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d    = '0;
          tx_done_d = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Guess intake: edge detect, A-Z validation, FIFO bookkeeping.
  always_comb begin
    push_req   = send && !send_prev_q;
    valid      = (letter >= 8'h41) && (letter <= 8'h5A);
    we         = 1'b0;
    overflow_d = 1'b0;
    bad_char_d = 1'b0;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push_req) begin
      if (!valid) begin
        bad_char_d = 1'b1;
      end else if ((count_q == CW'(DEPTH)) && !pop) begin
        overflow_d = 1'b1;
      end else begin
        we = 1'b1;
      end
    end

    // At full, write and pop hit the same slot; the pop already took the old byte.
    if (we) begin
      mem_d[wr_ptr_q] = letter;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (we && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !we) begin
      count_d = count_q - CW'(1);
    end

    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      send_prev_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      overflow_q  <= 1'b0;
      bad_char_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      send_prev_q <= send;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      overflow_q  <= overflow_d;
      bad_char_q  <= bad_char_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;
  assign overflow = overflow_q;
  assign bad_char = bad_char_q;
  assign count    = count_q;

endmodule

// File: tb/tb_guess_uart_tx.sv
// tb_guess_uart_tx: self-checking bench for guess_uart_tx.
// A timeline model predicts, for every accepted guess, the edge at which its
// frame starts; all outputs are derived from those frame windows each cycle.
module tb_guess_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] letter;
  logic       tx, busy, tx_done, overflow, bad_char;
  logic [2:0] count;

  always #5 clk = ~clk;

  guess_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .letter   (letter),
    .send     (send),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (tx_done),
    .overflow (overflow),
    .bad_char (bad_char),
    .count    (count)
  );

  typedef struct {
    int         push;
    int         pop;
    logic [7:0] ch;
  } ent_t;

  typedef struct {
    logic [7:0] ch;
    logic       exp_bad;
  } vec_t;

  ent_t mq[$];
  int   e = 0;
  bit   sp = 1'b0;
  bit   m_ovf = 1'b0;
  bit   m_bad = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
  endtask

  // Apply the rules for the inputs present at edge ee.
  function automatic void model_edge(input int ee);
    int occ;
    int p;
    m_ovf = 1'b0;
    m_bad = 1'b0;
    if (rst) begin
      mq.delete();
      sp = 1'b0;
      return;
    end
    if (send && !sp) begin
      if (letter >= 8'h41 && letter <= 8'h5A) begin
        occ = 0;
        foreach (mq[i]) if (mq[i].push < ee && mq[i].pop > ee) occ++;
        if (occ < DEPTH) begin
          p = ee + 1;
          if (mq.size() > 0 && mq[$].pop + FRAME > p) p = mq[$].pop + FRAME;
          mq.push_back('{push: ee, pop: p, ch: letter});
        end else begin
          m_ovf = 1'b1;
        end
      end else begin
        m_bad = 1'b1;
      end
    end
    sp = send;
  endfunction

  // One clock edge, then compare every output to the model.
  task automatic step;
    logic xt, xd, xb;
    int   xc;
    model_edge(e + 1);
    @(posedge clk);
    e++;
    #1;
    xt = 1'b1; xd = 1'b0; xb = 1'b0; xc = 0;
    foreach (mq[i]) begin
      int p;
      int off;
      logic [7:0] c;
      p = mq[i].pop;
      c = mq[i].ch;
      off = e - 1 - p;
      if (off >= 0 && off < FRAME) begin
        if (off / CPB == 0) xt = 1'b0;
        else if (off / CPB < 9) xt = c[off / CPB - 1];
      end
      if (e == p + FRAME) xd = 1'b1;
      if (mq[i].push <= e && e < p + FRAME) xb = 1'b1;
      if (mq[i].push <= e && p > e) xc++;
    end
    check("tx", 8'(tx), 8'(xt));
    check("tx_done", 8'(tx_done), 8'(xd));
    check("busy", 8'(busy), 8'(xb));
    check("count", 8'(count), 8'(xc));
    check("overflow", 8'(overflow), 8'(m_ovf));
    check("bad_char", 8'(bad_char), 8'(m_bad));
  endtask

  task automatic do_reset;
    rst = 1'b1; send = 1'b0;
    step; step;
    rst = 1'b0;
  endtask

  task automatic push1(input logic [7:0] ch);
    letter = ch; send = 1'b1; step;
    send = 1'b0; step;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[8];
    logic [9:0] pat;
    logic [7:0] word[5];
    int         peak, dones, target;

    rst = 1'b1; send = 1'b0; letter = 8'h00;

    // Reset state
    do_reset;
    check("rst_tx", 8'(tx), 8'd1);
    check("rst_count", 8'(count), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);

    // 'O' frame: start, LSB-first data, stop, 4 cycles each
    pat = {1'b1, 8'h4F, 1'b0};
    letter = 8'h4F; send = 1'b1; step;
    send = 1'b0; step;
    for (int i = 0; i < FRAME; i++) begin
      step;
      check("o_tx", 8'(tx), 8'(pat[i / CPB]));
      if (i == FRAME - 2) check("o_busy_hi", 8'(busy), 8'd1);
      if (i == FRAME - 1) begin
        check("o_done", 8'(tx_done), 8'd1);
        check("o_busy_fall", 8'(busy), 8'd0);
      end
    end

    // Held send gives exactly one guess
    do_reset;
    letter = 8'h4D; send = 1'b1; peak = 0;
    for (int i = 0; i < 10; i++) begin
      step;
      if (int'(count) > peak) peak = int'(count);
    end
    send = 1'b0; dones = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      step;
      dones += int'(tx_done);
    end
    check("hold_peak", 8'(peak), 8'd1);
    check("hold_dones", 8'(dones), 8'd1);

    // MOORE fills the FIFO, P overflows, S lands on the STOP->START pop at full
    do_reset;
    word = '{8'h4D, 8'h4F, 8'h4F, 8'h52, 8'h45};
    for (int i = 0; i < 5; i++) push1(word[i]);
    check("fill_count", 8'(count), 8'd4);
    letter = 8'h50; send = 1'b1; step;
    check("ovf_p", 8'(overflow), 8'd1);
    send = 1'b0; step;
    check("ovf_p_pulse", 8'(overflow), 8'd0);
    target = mq[0].pop + FRAME;
    while (e < target - 1) step;
    letter = 8'h53; send = 1'b1; step;
    check("full_pop_ovf", 8'(overflow), 8'd0);
    check("full_pop_count", 8'(count), 8'd4);
    dones = int'(tx_done);
    send = 1'b0;
    for (int i = 0; i < 5 * FRAME + 10; i++) begin
      step;
      dones += int'(tx_done);
    end
    check("moore_dones", 8'(dones), 8'd6);

    // Validation table
    do_reset;
    vecs[0] = '{8'h61, 1'b1};
    vecs[1] = '{8'h31, 1'b1};
    vecs[2] = '{8'h40, 1'b1};
    vecs[3] = '{8'h5B, 1'b1};
    vecs[4] = '{8'h7A, 1'b1};
    vecs[5] = '{8'h41, 1'b0};
    vecs[6] = '{8'h5A, 1'b0};
    vecs[7] = '{8'h00, 1'b1};
    for (int i = 0; i < 8; i++) begin
      letter = vecs[i].ch; send = 1'b1; step;
      check("tbl_bad", 8'(bad_char), 8'(vecs[i].exp_bad));
      send = 1'b0; step;
      if (i == 4) check("tbl_count0", 8'(count), 8'd0);
    end
    for (int i = 0; i < 2 * FRAME + 10; i++) step;

    // Reset during data bit 3 of 'L' with two more queued
    do_reset;
    push1(8'h4C); push1(8'h41); push1(8'h42);
    target = mq[0].pop + 4 * CPB + 1;
    while (e < target - 1) step;
    rst = 1'b1; step; rst = 1'b0;
    check("midrst_tx", 8'(tx), 8'd1);
    check("midrst_count", 8'(count), 8'd0);
    check("midrst_busy", 8'(busy), 8'd0);
    dones = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      step;
      dones += int'(tx_done);
    end
    check("midrst_nodone", 8'(dones), 8'd0);
    push1(8'h59);
    dones = 0;
    for (int i = 0; i < FRAME + 5; i++) begin
      step;
      dones += int'(tx_done);
    end
    check("y_done", 8'(dones), 8'd1);

    // Randomised traffic with occasional resets
    do_reset;
    for (int i = 0; i < 2000; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      send = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) letter = 8'h41 + 8'($urandom_range(0, 25));
      else letter = 8'($urandom);
      step;
    end
    rst = 1'b0; send = 1'b0;
    for (int i = 0; i < (DEPTH + 1) * FRAME + 10; i++) step;
    check("drain_busy", 8'(busy), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
